clock_time_setter: RTL

// Writer side of the clock digit registers' set/new_val load interface (today tied off to 0).
// - Snapshots the running time into a shadow copy.
// - Lets the user edit HH:MM with the debounced inc/next press pulses.
// - On leaving set mode, commits the edited time into the six BCD digit registers, one digit per cycle.

---
 rtl/clock_time_setter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/clock_time_setter.sv
// Set-mode writer for the clock digit registers: snapshot, HH:MM edit, 6-cycle BCD commit.
// Optional blink of the selected digit when CLOCK_SET_BLINK_EN is defined.
module clock_time_setter #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        set_mode,
    input  logic        inc_press,
    input  logic        next_press,
    input  logic [23:0] cur_time,
    output logic [15:0] edit_time,
    output logic [3:0]  sel_onehot,
    output logic [5:0]  set_en,
    output logic [3:0]  new_val,
    output logic        busy,
    output logic        blank_sel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EDIT,
        S_COMMIT
    } state_t;

    localparam logic [3:0] SEL_HRT = 4'b1000;
    localparam logic [3:0] SEL_HRU = 4'b0100;
    localparam logic [3:0] SEL_MNT = 4'b0010;
    localparam logic [3:0] SEL_MNU = 4'b0001;

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_edit;
    logic [3:0]  r_sel;
    logic [5:0]  r_set_en;
    logic [3:0]  r_new_val;
    logic        r_busy;

    logic [15:0] w_edit_inc;
    logic [3:0]  w_ht;
    logic [3:0]  w_hu;
    logic [3:0]  w_mt;
    logic [3:0]  w_mu;
    logic        w_unused_bits;

    assign edit_time  = r_edit;
    assign sel_onehot = r_sel;
    assign set_en     = r_set_en;
    assign new_val    = r_new_val;
    assign busy       = r_busy;

    // Commit order: secU, secT, minU, minT, hrU, hrT; seconds always 0
    function automatic logic [3:0] f_digit(
        input logic [2:0]  idx,
        input logic [15:0] t
    );
        logic [3:0] d;
        case (idx)
            3'd2:    d = t[3:0];
            3'd3:    d = t[7:4];
            3'd4:    d = t[11:8];
            3'd5:    d = t[15:12];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        w_ht = r_edit[15:12];
        w_hu = r_edit[11:8];
        w_mt = r_edit[7:4];
        w_mu = r_edit[3:0];
        case (r_sel)
            SEL_HRT: begin
                w_ht = (r_edit[15:12] >= 4'd2) ? 4'd0 : r_edit[15:12] + 4'd1;
                if (w_ht == 4'd2 && r_edit[11:8] > 4'd3)
                    w_hu = 4'd3;
            end
            SEL_HRU: begin
                if (r_edit[15:12] == 4'd2)
                    w_hu = (r_edit[11:8] >= 4'd3) ? 4'd0 : r_edit[11:8] + 4'd1;
                else
                    w_hu = (r_edit[11:8] >= 4'd9) ? 4'd0 : r_edit[11:8] + 4'd1;
            end
            SEL_MNT: w_mt = (r_edit[7:4] >= 4'd5) ? 4'd0 : r_edit[7:4] + 4'd1;
            SEL_MNU: w_mu = (r_edit[3:0] >= 4'd9) ? 4'd0 : r_edit[3:0] + 4'd1;
            default: ;
        endcase
        w_edit_inc = {w_ht, w_hu, w_mt, w_mu};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_edit    <= 16'd0;
            r_sel     <= 4'd0;
            r_set_en  <= 6'd0;
            r_new_val <= 4'd0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_set_en  <= 6'd0;
                    r_new_val <= 4'd0;
                    if (set_mode) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_edit  <= cur_time[23:8];
                    r_sel   <= SEL_HRT;
                    r_state <= S_EDIT;
                end
                S_EDIT: begin
                    if (!set_mode) begin
                        r_state   <= S_COMMIT;
                        r_sel     <= 4'd0;
                        r_idx     <= 3'd0;
                        r_set_en  <= 6'b000001;
                        r_new_val <= 4'd0;
                    end else if (next_press) begin
                        r_sel <= {r_sel[0], r_sel[3:1]};
                    end else if (inc_press) begin
                        r_edit <= w_edit_inc;
                    end
                end
                S_COMMIT: begin
                    if (r_idx == 3'd5) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_set_en  <= 6'd0;
                        r_new_val <= 4'd0;
                    end else begin
                        r_idx     <= r_idx + 3'd1;
                        r_set_en  <= {r_set_en[4:0], 1'b0};
                        r_new_val <= f_digit(r_idx + 3'd1, r_edit);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CLOCK_SET_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] r_blink_cnt;
    logic          r_blank;

    assign blank_sel     = r_blank;
    assign w_unused_bits = ^cur_time[7:0];

    // Any press shows the digit solid and restarts the blink period
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (r_state == S_EDIT && set_mode) begin
            if (inc_press || next_press) begin
                r_blink_cnt <= '0;
                r_blank     <= 1'b0;
            end else if (r_blink_cnt == CNT_LAST) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blank <= 1'b0;
            if (r_state == S_LOAD)
                r_blink_cnt <= '0;
        end
    end
`else
    assign blank_sel     = 1'b0;
    assign w_unused_bits = ^cur_time[7:0] ^ (BLINK_DIV != 0);
`endif

endmodule
